serial_bus_arbiter: RTL and testbench
=====================================

// Module: serial_bus_arbiter
// PURPOSE
//  Shares the single serial address/data bus between NM masters and NS slaves (the external-memory
//  slave and its siblings). Grants one master at a time by round-robin, selects the target slave,
//  drives each slave's BusAvailable, and supports split reads: a slave asserting hold releases the
//  bus, and the return phase is re-granted to the original master once hold drops.
// PARAMETERS
//  NM       3     number of masters (2..8)
//  NS       3     number of slaves (1..8)
//  SW       2     slave-id width, = max(1,$clog2(NS))
//  TIMEOUT  255   max cycles one grant may last before forced release (8-bit counter)
// PORTS
//  clk           in   1      single clock, rising edge
//  reset         in   1      synchronous, active-high
//  req           in   NM     per-master bus request; held high for the whole transaction
//  tgt           in   NM*SW  per-master target slave id; master m uses tgt[m*SW+:SW]
//  slave_hold    in   NS     per-slave hold (read data not yet available)
//  grant         out  NM     one-hot grant; all-zero when bus idle
//  slave_sel     out  NS     one-hot select of the slave currently on the bus
//  BusAvailable  out  NS     per-slave bus-free indication
//  bus_busy      out  1      OR of grant
//  timeout_err   out  1      one-cycle pulse on forced release
// BEHAVIOUR
//  Reset: grant=0, slave_sel=0, BusAvailable=0, bus_busy=0, timeout_err=0, rr_ptr=0,
//   split table cleared, state=IDLE. Reset mid-transaction aborts it identically.
//  All outputs registered. States: IDLE, BUSY, SPLIT_RET.
//  IDLE (priority order, evaluated each cycle):
//   1. Split return: lowest slave s with split_valid[s]=1 and slave_hold[s]=0 -> next cycle
//      grant=onehot(split_owner[s]), slave_sel[s]=1, BusAvailable[s]=1, state SPLIT_RET.
//   2. Eligible m: req[m]=1, tgt[m]<NS, master not split-pending, split_valid[tgt[m]]=0.
//      Winner = first eligible at or after rr_ptr (cyclic). Next cycle grant[m]=1,
//      slave_sel/BusAvailable[tgt[m]]=1, state BUSY; rr_ptr <= (m+1) mod NM.
//   3. Otherwise remain IDLE, outputs zero.
//   Req-to-grant latency exactly 1 cycle; at least one IDLE cycle between grants (turnaround).
//   tgt sampled only at grant; later changes ignored.
//  BUSY:
//   - slave_hold[sel] rises -> record split_valid[sel]=1, split_owner[sel]=owner, mark owner
//     split-pending; next cycle grant=0, slave_sel=0, BusAvailable=0, IDLE.
//   - req[owner] falls -> next cycle outputs zero, IDLE.
//   - Both in same cycle: hold wins (split recorded).
//  SPLIT_RET: ends when req[owner] falls -> clear split_valid[s] and owner split-pending, IDLE.
//   hold re-asserting in SPLIT_RET (burst read) records a new split exactly as in BUSY.
//  Timeout: 8-bit counter cleared on entry to BUSY/SPLIT_RET, +1 per cycle there; at TIMEOUT:
//   grant/slave_sel/BusAvailable=0, clear any split entry of the owner, timeout_err=1 for 1
//   cycle, IDLE. The counter saturates and never wraps.
//  Split-pending masters whose req drops while waiting: entry is kept until its return phase
//   completes or times out (return granted; req low ends it after 1 cycle).
// STRUCTURE
//  Shared package (bus_pkg): state encodings ARB_IDLE/ARB_BUSY/ARB_SPLIT_RET, SW function,
//   TIMEOUT width constant. Split table = NS entries {valid, owner[$clog2(NM)-1:0]}.
//  One sub-module: rr_pick (combinational cyclic priority encoder: req vector + ptr ->
//   one-hot winner + valid), reused by other arbiters in the bus.
// TESTING (NM=3, NS=3, TIMEOUT=20)
//  1. req=3'b011, tgt0=1, tgt1=2, rr_ptr=0 -> grant=001, slave_sel=010 next cycle; drop req0
//     -> one idle cycle, then grant=010, slave_sel=100, rr_ptr=2.
//  2. M0 granted to slave0; slave_hold[0]=1 -> grant=000 next cycle; M1 (tgt=2) granted next;
//     hold[0] drops while M1 busy -> after M1 drops req, grant=001, BusAvailable=001.
//  3. M2 requests slave0 while slave0 split-pending -> not granted until return completes.
//  4. Hold rise and req fall same cycle -> split recorded; return grant issued later.
//  5. Hold req high 20 cycles -> timeout_err pulse, grant=000, split table clear for owner.
//  6. Reset asserted in SPLIT_RET -> all outputs 0 next cycle, prior split not re-granted.

Source files
------------

// File: rtl/bus_pkg.sv
// ============================================================================
// Module  : bus_pkg
// Brief   : Shared types and helpers for the serial bus arbiters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_pkg;

    localparam int c_TO_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_BUSY      = 2'd1,
        ARB_SPLIT_RET = 2'd2
    } arb_state_t;

    // Index width for a set of n items, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational cyclic priority encoder; first request at/after ptr.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
    import bus_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = id_width(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_onehot,
    output logic          o_valid
);

    logic [2*N-1:0] w_dbl_req;
    logic [2*N-1:0] w_dbl_win;
    logic [N-1:0]   w_rot_req;
    logic [N-1:0]   w_rot_win;
    logic           w_found;

    // Rotate so ptr sits at bit 0, pick the lowest bit, rotate back.
    assign w_dbl_req = {i_req, i_req} >> i_ptr;
    assign w_rot_req = w_dbl_req[N-1:0];

    always_comb begin
        w_rot_win = '0;
        w_found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (w_rot_req[i] && !w_found) begin
                w_rot_win[i] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

    assign w_dbl_win = {w_rot_win, w_rot_win} << i_ptr;
    assign o_onehot  = w_dbl_win[2*N-1:N];
    assign o_valid   = |i_req;

endmodule

`default_nettype wire

// File: rtl/serial_bus_arbiter.sv
// ============================================================================
// Module  : serial_bus_arbiter
// Brief   : Round-robin master/slave arbiter for the serial bus with split reads.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_bus_arbiter
    import bus_pkg::*;
#(
    parameter int NM      = 3,
    parameter int NS      = 3,
    parameter int SW      = id_width(NS),
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NM-1:0]    req,
    input  logic [NM*SW-1:0] tgt,
    input  logic [NS-1:0]    slave_hold,
    output logic [NM-1:0]    grant,
    output logic [NS-1:0]    slave_sel,
    output logic [NS-1:0]    BusAvailable,
    output logic             bus_busy,
    output logic             timeout_err
);

    localparam int                MW        = id_width(NM);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT - 1);
    localparam logic [NM-1:0]     c_M_ONE   = NM'(1);
    localparam logic [NS-1:0]     c_S_ONE   = NS'(1);
    localparam logic [MW-1:0]     c_M_LAST  = MW'(NM - 1);

    arb_state_t          r_state;
    logic [MW-1:0]       r_owner;
    logic [MW-1:0]       r_rr_ptr;
    logic [SW-1:0]       r_sel;
    logic [c_TO_W-1:0]   r_cnt;
    logic [NS-1:0]       r_split_valid;
    logic [MW-1:0]       r_split_owner [NS];
    logic [NM-1:0]       r_pend;
    logic [NM-1:0]       r_grant;
    logic [NS-1:0]       r_slave_sel;
    logic [NS-1:0]       r_bus_avail;
    logic                r_bus_busy;
    logic                r_timeout_err;

    logic [SW-1:0]       w_tgt [NM];
    logic [NM-1:0]       w_elig;
    logic [NM-1:0]       w_pick_oh;
    logic                w_pick_valid;
    logic [MW-1:0]       w_pick_idx;
    logic [SW-1:0]       w_pick_tgt;
    logic                w_ret_valid;
    logic [SW-1:0]       w_ret_slave;
    logic                w_hold_ev;
    logic                w_drop;
    logic                w_to;
    logic                w_end;

    // A master is eligible only if neither it nor its target has a split outstanding.
    always_comb begin
        w_elig = '0;
        for (int m = 0; m < NM; m++) begin
            w_tgt[m] = tgt[m*SW +: SW];
            if (req[m] && !r_pend[m] && (int'(w_tgt[m]) < NS)) begin
                w_elig[m] = !r_split_valid[w_tgt[m]];
            end
        end
    end

    rr_pick #(
        .N  (NM),
        .PW (MW)
    ) u_rr_pick (
        .i_req    (w_elig),
        .i_ptr    (r_rr_ptr),
        .o_onehot (w_pick_oh),
        .o_valid  (w_pick_valid)
    );

    always_comb begin
        w_pick_idx = '0;
        w_pick_tgt = '0;
        for (int m = 0; m < NM; m++) begin
            if (w_pick_oh[m]) begin
                w_pick_idx = MW'(m);
                w_pick_tgt = w_tgt[m];
            end
        end
    end

    // Lowest-numbered slave whose split data is now ready.
    always_comb begin
        w_ret_valid = 1'b0;
        w_ret_slave = '0;
        for (int s = NS - 1; s >= 0; s--) begin
            if (r_split_valid[s] && !slave_hold[s]) begin
                w_ret_valid = 1'b1;
                w_ret_slave = SW'(s);
            end
        end
    end

    assign w_hold_ev = slave_hold[r_sel];
    assign w_drop    = !req[r_owner];
    assign w_to      = (r_cnt == c_TO_LAST);
    assign w_end     = w_hold_ev || w_drop || w_to;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ARB_IDLE;
            r_owner       <= '0;
            r_rr_ptr      <= '0;
            r_sel         <= '0;
            r_cnt         <= '0;
            r_split_valid <= '0;
            r_pend        <= '0;
            r_grant       <= '0;
            r_slave_sel   <= '0;
            r_bus_avail   <= '0;
            r_bus_busy    <= 1'b0;
            r_timeout_err <= 1'b0;
            for (int s = 0; s < NS; s++) begin
                r_split_owner[s] <= '0;
            end
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_ret_valid) begin
                        r_state     <= ARB_SPLIT_RET;
                        r_owner     <= r_split_owner[w_ret_slave];
                        r_sel       <= w_ret_slave;
                        r_cnt       <= '0;
                        r_grant     <= c_M_ONE << r_split_owner[w_ret_slave];
                        r_slave_sel <= c_S_ONE << w_ret_slave;
                        r_bus_avail <= c_S_ONE << w_ret_slave;
                        r_bus_busy  <= 1'b1;
                    end else if (w_pick_valid) begin
                        r_state     <= ARB_BUSY;
                        r_owner     <= w_pick_idx;
                        r_sel       <= w_pick_tgt;
                        r_cnt       <= '0;
                        r_grant     <= w_pick_oh;
                        r_slave_sel <= c_S_ONE << w_pick_tgt;
                        r_bus_avail <= c_S_ONE << w_pick_tgt;
                        r_bus_busy  <= 1'b1;
                        r_rr_ptr    <= (w_pick_idx == c_M_LAST) ? '0 : w_pick_idx + 1'b1;
                    end
                end
                ARB_BUSY, ARB_SPLIT_RET: begin
                    if (w_end) begin
                        r_state     <= ARB_IDLE;
                        r_grant     <= '0;
                        r_slave_sel <= '0;
                        r_bus_avail <= '0;
                        r_bus_busy  <= 1'b0;
                        // Hold beats a simultaneous req drop; timeout only when neither.
                        if (w_hold_ev) begin
                            r_split_valid[r_sel] <= 1'b1;
                            r_split_owner[r_sel] <= r_owner;
                            r_pend[r_owner]      <= 1'b1;
                        end else if (w_drop) begin
                            if (r_state == ARB_SPLIT_RET) begin
                                r_split_valid[r_sel] <= 1'b0;
                                r_pend[r_owner]      <= 1'b0;
                            end
                        end else begin
                            r_timeout_err   <= 1'b1;
                            r_pend[r_owner] <= 1'b0;
                            for (int s = 0; s < NS; s++) begin
                                if (r_split_valid[s] && (r_split_owner[s] == r_owner)) begin
                                    r_split_valid[s] <= 1'b0;
                                end
                            end
                        end
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign grant        = r_grant;
    assign slave_sel    = r_slave_sel;
    assign BusAvailable = r_bus_avail;
    assign bus_busy     = r_bus_busy;
    assign timeout_err  = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_serial_bus_arbiter.sv
// ============================================================================
// Module  : tb_serial_bus_arbiter
// Brief   : Self-checking bench for serial_bus_arbiter (NM=3, NS=3, TIMEOUT=20).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_bus_arbiter;

    localparam int NM      = 3;
    localparam int NS      = 3;
    localparam int SW      = 2;
    localparam int TIMEOUT = 20;

    logic             clk;
    logic             reset;
    logic [NM-1:0]    req;
    logic [NM*SW-1:0] tgt;
    logic [NS-1:0]    slave_hold;
    logic [NM-1:0]    grant;
    logic [NS-1:0]    slave_sel;
    logic [NS-1:0]    BusAvailable;
    logic             bus_busy;
    logic             timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    serial_bus_arbiter #(
        .NM      (NM),
        .NS      (NS),
        .SW      (SW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .tgt          (tgt),
        .slave_hold   (slave_hold),
        .grant        (grant),
        .slave_sel    (slave_sel),
        .BusAvailable (BusAvailable),
        .bus_busy     (bus_busy),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: who owns the bus, which slave, and who is waiting on which slave.
    int m_owner;
    int m_slave;
    int m_cnt;
    int m_rr;
    bit m_ret;
    bit m_to;
    int sp_own [NS];

    function automatic bit pending(input int m);
        for (int s = 0; s < NS; s++) if (sp_own[s] == m) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_slave = 0; m_cnt = 0; m_rr = 0; m_ret = 0; m_to = 0;
        for (int s = 0; s < NS; s++) sp_own[s] = -1;
    endtask

    task automatic model_step(input logic [2:0] rq, input logic [5:0] tg, input logic [2:0] hd);
        int rs, t, m;
        m_to = 0;
        if (m_owner < 0) begin
            rs = -1;
            for (int s = 0; s < NS; s++) if (rs < 0 && sp_own[s] >= 0 && !hd[s]) rs = s;
            if (rs >= 0) begin
                m_owner = sp_own[rs]; m_slave = rs; m_ret = 1; m_cnt = 0;
            end else begin
                for (int k = 0; k < NM; k++) begin
                    m = (m_rr + k) % NM;
                    t = int'(tg[m*2 +: 2]);
                    if (m_owner < 0 && rq[m] && t < NS && !pending(m)) begin
                        if (sp_own[t] < 0) begin
                            m_owner = m; m_slave = t; m_ret = 0; m_cnt = 0;
                            m_rr = (m + 1) % NM;
                        end
                    end
                end
            end
        end else begin
            m_cnt++;
            if (hd[m_slave]) begin
                sp_own[m_slave] = m_owner; m_owner = -1;
            end else if (!rq[m_owner]) begin
                if (m_ret) sp_own[m_slave] = -1;
                m_owner = -1;
            end else if (m_cnt >= TIMEOUT) begin
                for (int s = 0; s < NS; s++) if (sp_own[s] == m_owner) sp_own[s] = -1;
                m_to = 1; m_owner = -1;
            end
        end
    endtask

    function automatic logic [10:0] model_out();
        logic [2:0] eg, es;
        eg = (m_owner >= 0) ? (3'b001 << m_owner) : 3'b000;
        es = (m_owner >= 0) ? (3'b001 << m_slave) : 3'b000;
        return {eg, es, es, |eg, m_to};
    endfunction

    function automatic logic [10:0] dut_out();
        return {grant, slave_sel, BusAvailable, bus_busy, timeout_err};
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: apply inputs, advance the model, compare all outputs.
    task automatic cyc(input logic r, input logic [2:0] rq, input logic [5:0] tg, input logic [2:0] hd);
        reset = r; req = rq; tgt = tg; slave_hold = hd;
        @(posedge clk);
        if (r) model_reset();
        else   model_step(rq, tg, hd);
        #1;
        chk("model", 16'(dut_out()), 16'(model_out()));
    endtask

    task automatic do_reset();
        cyc(1'b1, 3'b000, 6'b0, 3'b000);
        cyc(1'b1, 3'b000, 6'b0, 3'b000);
        chk("reset_state", 16'(dut_out()), 16'h0);
    endtask

    typedef struct {
        logic [2:0] req;
        logic [5:0] tgt;
        logic [2:0] hold;
        logic [2:0] eg;
        logic [2:0] es;
    } vec_t;

    vec_t tbl [10];
    logic [2:0] rq_r;
    logic [5:0] tg_r;
    logic [2:0] hd_r;

    initial begin
        // tgt packs {t2,t1,t0}; here t0=1, t1=2, t2=0.
        tbl[0] = '{3'b011, 6'b001001, 3'b000, 3'b001, 3'b010};
        tbl[1] = '{3'b011, 6'b001001, 3'b000, 3'b001, 3'b010};
        tbl[2] = '{3'b010, 6'b001001, 3'b000, 3'b000, 3'b000};
        tbl[3] = '{3'b010, 6'b001001, 3'b000, 3'b010, 3'b100};
        tbl[4] = '{3'b010, 6'b001001, 3'b000, 3'b010, 3'b100};
        tbl[5] = '{3'b000, 6'b001001, 3'b000, 3'b000, 3'b000};
        tbl[6] = '{3'b111, 6'b001001, 3'b000, 3'b100, 3'b001};
        tbl[7] = '{3'b000, 6'b001001, 3'b000, 3'b000, 3'b000};
        tbl[8] = '{3'b111, 6'b001001, 3'b000, 3'b001, 3'b010};
        tbl[9] = '{3'b000, 6'b001001, 3'b000, 3'b000, 3'b000};

        model_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, tbl[i].req, tbl[i].tgt, tbl[i].hold);
            chk($sformatf("vec%0d", i), 16'({grant, slave_sel}), 16'({tbl[i].eg, tbl[i].es}));
        end

        // Split on slave0 by M0, M1 served meanwhile, then return to M0.
        do_reset();
        cyc(1'b0, 3'b001, 6'b001000, 3'b000);
        cyc(1'b0, 3'b001, 6'b001000, 3'b001);
        chk("split_release", 16'(grant), 16'h0);
        cyc(1'b0, 3'b011, 6'b001000, 3'b001);
        chk("other_master", 16'({grant, slave_sel}), 16'({3'b010, 3'b100}));
        cyc(1'b0, 3'b011, 6'b001000, 3'b000);
        cyc(1'b0, 3'b001, 6'b001000, 3'b000);
        cyc(1'b0, 3'b001, 6'b001000, 3'b000);
        chk("split_return", 16'({grant, BusAvailable}), 16'({3'b001, 3'b001}));
        cyc(1'b0, 3'b000, 6'b001000, 3'b000);

        // M2 targets a split-pending slave and must wait for the return to finish.
        do_reset();
        cyc(1'b0, 3'b001, 6'b000000, 3'b000);
        cyc(1'b0, 3'b001, 6'b000000, 3'b001);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 3'b101, 6'b000000, 3'b001);
            chk("blocked_m2", 16'(grant), 16'h0);
        end
        cyc(1'b0, 3'b101, 6'b000000, 3'b000);
        chk("ret_before_m2", 16'(grant), 16'(3'b001));
        cyc(1'b0, 3'b100, 6'b000000, 3'b000);
        cyc(1'b0, 3'b100, 6'b000000, 3'b000);
        chk("m2_after_ret", 16'({grant, slave_sel}), 16'({3'b100, 3'b001}));
        cyc(1'b0, 3'b000, 6'b000000, 3'b000);

        // Hold rise and req fall together: split wins, return still granted later.
        do_reset();
        cyc(1'b0, 3'b010, 6'b000100, 3'b000);
        cyc(1'b0, 3'b000, 6'b000100, 3'b010);
        cyc(1'b0, 3'b000, 6'b000100, 3'b010);
        chk("hold_vs_drop", 16'(grant), 16'h0);
        cyc(1'b0, 3'b000, 6'b000100, 3'b000);
        chk("late_return", 16'({grant, slave_sel}), 16'({3'b010, 3'b010}));
        cyc(1'b0, 3'b000, 6'b000100, 3'b000);
        cyc(1'b0, 3'b000, 6'b000100, 3'b000);
        chk("no_regrant", 16'(grant), 16'h0);

        // Timeout during a split return clears the owner's entry.
        do_reset();
        cyc(1'b0, 3'b001, 6'b000010, 3'b000);
        cyc(1'b0, 3'b001, 6'b000010, 3'b100);
        cyc(1'b0, 3'b001, 6'b000010, 3'b000);
        for (int k = 2; k <= TIMEOUT; k++) begin
            cyc(1'b0, 3'b001, 6'b000010, 3'b000);
            chk("held_grant", 16'({grant, timeout_err}), 16'({3'b001, 1'b0}));
        end
        cyc(1'b0, 3'b001, 6'b000010, 3'b000);
        chk("timeout", 16'({grant, timeout_err}), 16'({3'b000, 1'b1}));
        cyc(1'b0, 3'b000, 6'b000010, 3'b000);
        chk("timeout_pulse", 16'({grant, timeout_err}), 16'h0);
        cyc(1'b0, 3'b000, 6'b000010, 3'b000);
        chk("timeout_cleared", 16'(grant), 16'h0);

        // Reset while in a split return aborts it and forgets the split.
        do_reset();
        cyc(1'b0, 3'b001, 6'b000001, 3'b000);
        cyc(1'b0, 3'b001, 6'b000001, 3'b010);
        cyc(1'b0, 3'b001, 6'b000001, 3'b000);
        chk("ret_active", 16'(grant), 16'(3'b001));
        cyc(1'b1, 3'b001, 6'b000001, 3'b000);
        chk("reset_in_ret", 16'(dut_out()), 16'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 3'b000, 6'b000001, 3'b000);
            chk("post_reset", 16'(grant), 16'h0);
        end

        // Randomized traffic against the model.
        do_reset();
        rq_r = 3'b000; tg_r = 6'b0; hd_r = 3'b000;
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < 3; b++) begin
                if ($urandom_range(0, 5) == 0) rq_r[b] = ~rq_r[b];
                hd_r[b] = ($urandom_range(0, 7) == 0);
            end
            if ($urandom_range(0, 7) == 0) tg_r = 6'($urandom());
            cyc(($urandom_range(0, 199) == 0), rq_r, tg_r, hd_r);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
